// File: rtl/risc16_pkg.sv
// rtl/risc16_pkg.sv - RiSC-16 opcodes, field positions, formats and encoder states
package risc16_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_LUI  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  localparam int OPC_MSB = 15;
  localparam int RA_LSB  = 10;
  localparam int RB_LSB  = 7;
  localparam int RC_LSB  = 0;
  localparam int SIMM_W  = 7;
  localparam int IMM_W   = 10;

  typedef enum logic [1:0] {
    FMT_RRR,
    FMT_RRI,
    FMT_RI
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD1,
    ST_HOLD2
  } enc_state_e;

  // Instruction format selected by the opcode
  function automatic fmt_e op_fmt(input logic [2:0] op);
    case (op)
      OP_ADD, OP_NAND: return FMT_RRR;
      OP_LUI:          return FMT_RI;
      default:         return FMT_RRI;
    endcase
  endfunction

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational RiSC-16 field packer with immediate range check
module instr_pack
  import risc16_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [2:0]  ra,
  input  logic [2:0]  rb,
  input  logic [2:0]  rc,
  input  logic [15:0] imm,
  output logic [15:0] word,
  output logic        legal
);

  // Pack fields by format and decide whether the immediate fits its field
  always_comb begin
    word  = '0;
    legal = 1'b1;
    word[OPC_MSB -: 3]  = op;
    word[RA_LSB +: 3]   = ra;
    case (op_fmt(op))
      FMT_RRR: begin
        word[RB_LSB +: 3] = rb;
        word[RC_LSB +: 3] = rc;
      end
      FMT_RRI: begin
        word[RB_LSB +: 3]   = rb;
        word[SIMM_W-1:0]    = imm[SIMM_W-1:0];
        // signed 7-bit range: bits above the sign bit must all copy it
        legal = (imm[15:SIMM_W-1] == '0) || (imm[15:SIMM_W-1] == '1);
        if (op == OP_JALR) begin
          legal = (imm == '0);
        end
      end
      default: begin
        word[IMM_W-1:0] = imm[IMM_W-1:0];
        legal = (imm[15:IMM_W] == '0);
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - decoded-field to packed-word stream encoder with MOVI expansion
module instr_encoder
  import risc16_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic              in_movi,
  input  logic [2:0]        in_ra,
  input  logic [2:0]        in_rb,
  input  logic [2:0]        in_rc,
  input  logic [15:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  input  logic              err_clr
);

  enc_state_e        state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] movi_addr;
  logic [15:0]       movi_word;
  logic              movi_pending;
  logic [2:0]        pk_op;
  logic [15:0]       pk_imm;
  logic [15:0]       pk_word;
  logic              pk_legal;
  logic              req_legal;
  logic              fire;
  logic              accept;
  logic              load_new;

  // MOVI word 1 is a LUI carrying the upper ten immediate bits
  always_comb begin
    pk_op  = in_op;
    pk_imm = in_imm;
    if (in_movi) begin
      pk_op  = OP_LUI;
      pk_imm = {6'b0, in_imm[15:6]};
    end
  end

  instr_pack u_pack (
    .op    (pk_op),
    .ra    (in_ra),
    .rb    (in_rb),
    .rc    (in_rc),
    .imm   (pk_imm),
    .word  (pk_word),
    .legal (pk_legal)
  );

  assign req_legal = in_movi | pk_legal;

  // Handshakes and next state; a new word may be loaded in the cycle the held one fires
  always_comb begin
    state_nx  = state;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    fire      = 1'b0;
    accept    = 1'b0;
    load_new  = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_HOLD1: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~movi_pending;
      end
      ST_HOLD2: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
    fire     = out_valid & out_ready;
    accept   = in_valid & in_ready;
    load_new = accept & req_legal;
    case (state)
      ST_IDLE: begin
        if (load_new) state_nx = ST_HOLD1;
      end
      ST_HOLD1: begin
        if (fire) begin
          if (movi_pending)  state_nx = ST_HOLD2;
          else if (load_new) state_nx = ST_HOLD1;
          else               state_nx = ST_IDLE;
        end
      end
      ST_HOLD2: begin
        if (fire) state_nx = load_new ? ST_HOLD1 : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Output word register; the MOVI second word and its address are fixed at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_instr    <= '0;
      out_addr     <= '0;
      movi_pending <= 1'b0;
      movi_word    <= '0;
      movi_addr    <= '0;
    end else if (load_new) begin
      out_instr    <= pk_word;
      out_addr     <= cnt;
      movi_pending <= in_movi;
      movi_word    <= {OP_ADDI, in_ra, in_ra, 1'b0, in_imm[5:0]};
      movi_addr    <= cnt + ADDR_W'(1);
    end else if (fire && state == ST_HOLD1 && movi_pending) begin
      out_instr    <= movi_word;
      out_addr     <= movi_addr;
      movi_pending <= 1'b0;
    end
  end

  // Address counter reserves one address per word, two for MOVI; a load overrides
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= RESET_ADDR;
    else if (addr_load) cnt <= start_addr;
    else if (load_new)  cnt <= cnt + ADDR_W'(in_movi ? 2 : 1);
  end

  // Sticky range error; a new error beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   err <= 1'b0;
    else if (accept && !req_legal) err <= 1'b1;
    else if (err_clr)             err <= 1'b0;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder
module tb_instr_encoder;
  import risc16_pkg::*;

  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic          in_movi;
  logic [2:0]    in_ra;
  logic [2:0]    in_rb;
  logic [2:0]    in_rc;
  logic [15:0]   in_imm;
  logic          addr_load;
  logic [AW-1:0] start_addr;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err;
  logic          err_clr;

  instr_encoder #(.ADDR_W(AW), .RESET_ADDR(4'd0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_movi    (in_movi),
    .in_ra      (in_ra),
    .in_rb      (in_rb),
    .in_rc      (in_rc),
    .in_imm     (in_imm),
    .addr_load  (addr_load),
    .start_addr (start_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .err        (err),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [15:0]   exp_i[$];
  logic [AW-1:0] exp_a[$];
  logic [AW-1:0] mcnt;
  bit            stop_rnd;
  logic [15:0]   imm_tab [9] = '{16'h0000, 16'h0001, 16'h003F, 16'h0040, 16'hFFC0,
                                 16'hFFBF, 16'h03FF, 16'h0400, 16'hFFFF};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input logic [2:0] op, input logic [2:0] ra,
                                             input logic [2:0] rb, input logic [2:0] rc,
                                             input logic [15:0] imm);
    case (op)
      3'd0, 3'd2: return {op, ra, rb, 4'b0000, rc};
      3'd3:       return {op, ra, imm[9:0]};
      default:    return {op, ra, rb, imm[6:0]};
    endcase
  endfunction

  function automatic bit model_legal(input logic [2:0] op, input logic [15:0] imm);
    int s;
    s = int'($signed(imm));
    case (op)
      3'd0, 3'd2: return 1'b1;
      3'd3:       return imm < 16'd1024;
      3'd7:       return imm == 16'd0;
      default:    return (s >= -64) && (s <= 63);
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Enter on a falling edge; returns on the falling edge after acceptance
  task automatic send(input logic [2:0] op, input logic mv, input logic [2:0] ra,
                      input logic [2:0] rb, input logic [2:0] rc, input logic [15:0] imm);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_op = op;
    in_movi = mv;
    in_ra = ra;
    in_rb = rb;
    in_rc = rc;
    in_imm = imm;
    while (!acc && n < 50) begin
      #1;
      acc = in_ready;
      @(posedge clk);
      n++;
      if (!acc) @(negedge clk);
    end
    if (acc) begin
      if (mv) begin
        exp_i.push_back(model_word(3'd3, ra, 3'd0, 3'd0, {6'b0, imm[15:6]}));
        exp_a.push_back(mcnt);
        exp_i.push_back(model_word(3'd1, ra, ra, 3'd0, {10'b0, imm[5:0]}));
        exp_a.push_back(mcnt + 4'd1);
        mcnt = mcnt + 4'd2;
      end else if (model_legal(op, imm)) begin
        exp_i.push_back(model_word(op, ra, rb, rc, imm));
        exp_a.push_back(mcnt);
        mcnt = mcnt + 4'd1;
      end
    end else begin
      check("accept_timeout", 32'd0, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_addr(input logic [AW-1:0] v);
    addr_load = 1'b1;
    start_addr = v;
    tick(1);
    addr_load = 1'b0;
    mcnt = v;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  // Output monitor: every fired word must be the next expected word and address
  always begin
    @(negedge clk);
    #3;
    if (rst_n && out_valid && out_ready) begin
      if (exp_i.size() == 0) begin
        check("spurious_word", {16'h0, out_instr}, 32'hFFFFFFFF);
      end else begin
        check("out_instr", out_instr, exp_i.pop_front());
        check("out_addr", out_addr, exp_a.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]   hi;
    logic [AW-1:0] ha;
    logic [2:0]    r_op;
    logic          r_mv;
    logic [15:0]   r_imm;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_op = 3'd0;
    in_movi = 1'b0;
    in_ra = 3'd0;
    in_rb = 3'd0;
    in_rc = 3'd0;
    in_imm = 16'd0;
    addr_load = 1'b0;
    start_addr = '0;
    out_ready = 1'b1;
    err_clr = 1'b0;
    mcnt = 4'd0;
    stop_rnd = 1'b0;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    tick(1);

    // ADD r1,r2,r3 -> 0x0503 @0 with one-cycle latency
    check("idle_out_valid", out_valid, 0);
    send(OP_ADD, 1'b0, 3'd1, 3'd2, 3'd3, 16'h0);
    check("latency_out_valid", out_valid, 1);
    check("add_word", out_instr, 16'h0503);
    tick(1);
    check("back_to_idle", out_valid, 0);

    // ADDI legal, then BEQ with out-of-range immediate dropped
    send(OP_ADDI, 1'b0, 3'd1, 3'd1, 3'd0, 16'hFFFF);
    send(OP_BEQ, 1'b0, 3'd0, 3'd0, 3'd0, 16'd64);
    check("beq_err", err, 1);
    check("beq_dropped", out_valid, 0);
    clear_err();
    check("err_cleared", err, 0);
    err_clr = 1'b1;
    send(OP_JALR, 1'b0, 3'd1, 3'd2, 3'd0, 16'd1);
    err_clr = 1'b0;
    check("err_set_wins", err, 1);
    clear_err();
    send(OP_LUI, 1'b0, 3'd4, 3'd0, 3'd0, 16'h0400);
    check("lui_err", err, 1);
    clear_err();
    send(OP_LUI, 1'b0, 3'd4, 3'd0, 3'd0, 16'h03FF);
    send(OP_SW, 1'b0, 3'd5, 3'd6, 3'd0, 16'hFFC0);
    send(OP_LW, 1'b0, 3'd7, 3'd1, 3'd0, 16'h003F);
    send(OP_JALR, 1'b0, 3'd7, 3'd3, 3'd0, 16'h0000);
    send(OP_NAND, 1'b0, 3'd2, 3'd5, 3'd6, 16'hBEEF);
    check("legal_no_err", err, 0);
    tick(2);

    // MOVI r2,0x1234: in_ready low while word 1 is held
    send(3'd0, 1'b1, 3'd2, 3'd0, 3'd0, 16'h1234);
    #1;
    check("movi_in_ready", in_ready, 0);
    check("movi_word1", out_instr, 16'h6848);
    tick(1);
    #1;
    check("movi_word2", out_instr, 16'h2934);
    tick(2);

    // Back-pressure: held word stable for five cycles, then one word per cycle
    out_ready = 1'b0;
    fork
      begin
        send(OP_ADD, 1'b0, 3'd1, 3'd1, 3'd1, 16'h0);
        send(OP_ADD, 1'b0, 3'd2, 3'd2, 3'd2, 16'h0);
        send(OP_NAND, 1'b0, 3'd3, 3'd3, 3'd3, 16'h0);
      end
      begin
        tick(1);
        #1;
        hi = out_instr;
        ha = out_addr;
        tick(1);
        for (int i = 0; i < 5; i++) begin
          #1;
          check("bp_instr_stable", out_instr, hi);
          check("bp_addr_stable", out_addr, ha);
          check("bp_in_ready", in_ready, 0);
          tick(1);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
          #1;
          check("bp_throughput", out_valid, 1);
          tick(1);
        end
      end
    join
    tick(2);

    // Randomised mix under random back-pressure
    fork
      begin
        while (!stop_rnd) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int k = 0; k < 24; k++) begin
      r_op = 3'($urandom_range(0, 7));
      r_mv = ($urandom_range(0, 4) == 0);
      r_imm = imm_tab[$urandom_range(0, 8)];
      send(r_op, r_mv, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), r_imm);
    end
    stop_rnd = 1'b1;
    tick(1);
    #1;
    out_ready = 1'b1;
    tick(6);
    check("rnd_drained", exp_i.size(), 0);
    clear_err();

    // Wrap at the all-ones address, then reload the counter during HOLD2
    load_addr(4'd15);
    send(3'd0, 1'b1, 3'd1, 3'd0, 3'd0, 16'h0040);
    check("wrap_lui", out_instr, 16'h6401);
    check("wrap_lui_addr", out_addr, 15);
    tick(1);
    check("wrap_addi_addr", out_addr, 0);
    load_addr(4'd8);
    send(OP_ADD, 1'b0, 3'd4, 3'd5, 3'd6, 16'h0);
    check("reload_addr", out_addr, 8);
    tick(2);

    // Reset while the second MOVI word is held
    send(OP_BEQ, 1'b0, 3'd0, 3'd0, 3'd0, 16'h1000);
    out_ready = 1'b0;
    send(3'd0, 1'b1, 3'd3, 3'd0, 3'd0, 16'h00FF);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_instr", out_instr, 0);
    check("midrst_out_addr", out_addr, 0);
    check("midrst_err", err, 0);
    exp_i.delete();
    exp_a.delete();
    mcnt = 4'd0;
    tick(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(4);
    check("no_addi_after_rst", out_valid, 0);
    send(OP_ADD, 1'b0, 3'd1, 3'd0, 3'd2, 16'h0);
    check("post_rst_addr", out_addr, 0);

    for (int i = 0; i < 20 && exp_i.size() != 0; i++) tick(1);
    tick(1);
    check("final_drain", exp_i.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
